// File: rtl/arith_pkg.sv
// Shared definitions for the operand sequencer and its comparator.
package arith_pkg;

    // Sequencer phases: waiting for A, waiting for B, sampling the result, presenting it.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WAIT_B = 2'd1,
        CMP    = 2'd2,
        OUT    = 2'd3
    } state_t;

    // Operand tag values carried on i_sel.
    localparam logic SEL_A = 1'b0;
    localparam logic SEL_B = 1'b1;

    // Default operand width shared by the sequencer and the comparator.
    localparam int DEF_BITS = 32;

endpackage

// File: rtl/porownanie.sv
// Combinational unsigned comparator: o_gt = 1 when i_a is strictly greater than i_b.
module porownanie
    import arith_pkg::*;
#(
    parameter int BITS = DEF_BITS
) (
    input  logic [BITS-1:0] i_a,
    input  logic [BITS-1:0] i_b,
    output logic            o_gt
);

    assign o_gt = (i_a > i_b);

endmodule

// File: rtl/sekwencer_porownania.sv
// Operand sequencer around porownanie: collects A then B over a valid/ready bus,
// registers the comparison, offers it on a valid/ready output, counts transfers
// and pulses o_error on out-of-order operand tags.
module sekwencer_porownania
    import arith_pkg::*;
#(
    parameter int BITS     = DEF_BITS,
    parameter int CNT_BITS = 8
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic [BITS-1:0]     i_data,
    input  logic                i_sel,
    input  logic                i_valid,
    output logic                o_ready,
    output logic                o_result,
    output logic                o_valid,
    input  logic                i_ready,
    output logic                o_error,
    output logic [CNT_BITS-1:0] o_count
);

    state_t              r_state;
    state_t              w_state_next;
    logic [BITS-1:0]     r_arg_a;
    logic [BITS-1:0]     r_arg_b;
    logic                r_result;
    logic                r_valid;
    logic                r_error;
    logic [CNT_BITS-1:0] r_count;

    logic w_accept;
    logic w_load_a;
    logic w_load_b;
    logic w_error_next;
    logic w_capture;
    logic w_transfer;
    logic w_gt;

    // Operands stay registered from capture to the next capture, so the
    // comparator inputs are quiet while the result is sampled and held.
    porownanie #(
        .BITS (BITS)
    ) u_porownanie (
        .i_a  (r_arg_a),
        .i_b  (r_arg_b),
        .o_gt (w_gt)
    );

    // Ready is a pure decode of the registered state: no path from i_valid.
    assign o_ready  = (r_state == IDLE) || (r_state == WAIT_B);
    assign w_accept = i_valid & o_ready;

    assign o_result = r_result;
    assign o_valid  = r_valid;
    assign o_error  = r_error;
    assign o_count  = r_count;

    // Next-state and datapath strobes for the operand/result handshake.
    always_comb begin
        w_state_next = r_state;
        w_load_a     = 1'b0;
        w_load_b     = 1'b0;
        w_error_next = 1'b0;
        w_capture    = 1'b0;
        w_transfer   = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    if (i_sel == SEL_A) begin
                        w_load_a     = 1'b1;
                        w_state_next = WAIT_B;
                    end else begin
                        // B without a preceding A is dropped.
                        w_error_next = 1'b1;
                    end
                end
            end
            WAIT_B: begin
                if (w_accept) begin
                    if (i_sel == SEL_B) begin
                        w_load_b     = 1'b1;
                        w_state_next = CMP;
                    end else begin
                        // A second A restarts the pair with the newer value.
                        w_load_a     = 1'b1;
                        w_error_next = 1'b1;
                    end
                end
            end
            CMP: begin
                w_capture    = 1'b1;
                w_state_next = OUT;
            end
            OUT: begin
                if (i_ready) begin
                    w_transfer   = 1'b1;
                    w_state_next = IDLE;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    // State register; reset abandons any pair in progress.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Operand, result, error-pulse and transfer-counter registers.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_arg_a  <= '0;
            r_arg_b  <= '0;
            r_result <= 1'b0;
            r_valid  <= 1'b0;
            r_error  <= 1'b0;
            r_count  <= '0;
        end else begin
            if (w_load_a) begin
                r_arg_a <= i_data;
            end
            if (w_load_b) begin
                r_arg_b <= i_data;
            end
            r_error <= w_error_next;
            if (w_capture) begin
                r_result <= w_gt;
                r_valid  <= 1'b1;
            end
            if (w_transfer) begin
                r_valid <= 1'b0;
                r_count <= r_count + 1'b1;
            end
        end
    end

endmodule

// File: doc/sekwencer_porownania.md
Name: sekwencer_porownania

Overview:
Synchronous front/back stage around the combinational comparator `porownanie`. Operands arrive one word at a time on a shared input bus with valid/ready handshake: A first, then B. The block holds both words stable, samples the comparator result into a register, and presents it on a valid/ready output channel. It also keeps a count of completed comparisons and flags protocol errors.

Parameters:
- BITS, 32: operand width, passed to `porownanie`.
- CNT_BITS, 8: width of the completed-comparison counter.

Ports:
- i_clk  in  1  clock; all state updates on the rising edge.
- i_rst  in  1  synchronous, active-high reset.
- i_data  in  BITS  operand word.
- i_sel  in  1  operand tag: 0 = argument A, 1 = argument B.
- i_valid  in  1  i_data/i_sel are valid this cycle.
- o_ready  out  1  block accepts a word this cycle.
- o_result  out  1  registered comparator result for the captured pair.
- o_valid  out  1  o_result is valid.
- i_ready  in  1  consumer accepts o_result.
- o_error  out  1  one-cycle pulse on a protocol error.
- o_count  out  CNT_BITS  number of completed output transfers, modulo 2^CNT_BITS.

Behaviour:
- Reset (i_rst=1 at an edge): state=IDLE, arg_A=0, arg_B=0, o_result=0, o_valid=0, o_error=0, o_count=0. i_rst overrides every other input. A reset in any state abandons the pair in progress; it is neither output nor counted.
- "Accept" means i_valid & o_ready at a rising edge.
- o_ready = 1 in IDLE and WAIT_B, 0 in CMP and OUT. It is decoded from the registered state only and has no combinational path from i_valid.
- States:
  - IDLE, accept with i_sel=0: arg_A <= i_data, go to WAIT_B.
  - IDLE, accept with i_sel=1: word discarded, o_error=1 next cycle, stay in IDLE.
  - WAIT_B, accept with i_sel=1: arg_B <= i_data, go to CMP.
  - WAIT_B, accept with i_sel=0: arg_A overwritten (restart), o_error=1 next cycle, stay in WAIT_B.
  - CMP, one cycle: o_result <= `porownanie` output for (arg_A, arg_B), o_valid <= 1, go to OUT.
  - OUT: o_valid=1 and o_result held stable until i_ready=1 at an edge. Then o_valid <= 0, o_count <= o_count+1, go to IDLE.
- Latency: B accepted at edge k -> o_valid=1 after edge k+1 (2 cycles from B accepted to result). Minimum 4 cycles per pair with i_ready held at 1.
- arg_A and arg_B stay stable from capture until the next capture, so the comparator inputs do not toggle in CMP or OUT.
- Comparator contract: `porownanie` output = 1 iff arg_A > arg_B (unsigned), else 0.
- o_count wraps from 2^CNT_BITS-1 to 0 with no flag.
- o_error is a pulse: 1 for exactly the cycle after the offending accept, otherwise 0.
- i_valid while o_ready=0 is ignored; no error, no capture.
- i_ready outside OUT is ignored.

Decomposition:
- Shared package `arith_pkg`:
  - state enum typedef {IDLE, WAIT_B, CMP, OUT};
  - localparams SEL_A=1'b0 and SEL_B=1'b1;
  - BITS default constant shared with the comparator.
- One sub-module: existing `porownanie` #(.BITS(BITS)), instantiated internally and driven from arg_A and arg_B.
- FSM, operand registers and counter stay in this module.

Test Plan:
- Basic pair: reset; send A=0x0000_0010 (sel=0), then B=0x0000_0005 (sel=1), with i_ready=1 -> o_valid=1 two cycles after B is accepted, o_result=1; o_count 0->1.
- Equal and less operands:
  - A=B=0xFFFF_FFFF -> o_result=0.
  - A=0x0, B=0x1 -> o_result=0.
  - o_count=2 after both transfers.
- Backpressure: hold i_ready=0 for 5 cycles in OUT -> o_valid and o_result stay stable and o_ready=0; an i_valid word offered meanwhile is ignored. Release i_ready -> one transfer, o_count increments once.
- Protocol errors:
  - sel=1 word in IDLE -> o_error pulses 1 cycle, state stays IDLE.
  - A=0x5, then A=0x9 in WAIT_B (o_error pulse), then B=0x7 -> o_result=1, computed from A=0x9.
- Reset mid-operation: assert i_rst in WAIT_B and again in OUT -> next cycle o_valid=0, o_ready=1, o_count unchanged-to-0 per reset, no output transfer.
- Counter wrap: CNT_BITS=2, perform 5 pairs -> o_count sequence 1,2,3,0,1.
